spike_affine_norm: RTL and testbench

- Parametrised successor of the per-timestep spiking layer-norm stage: for each timestep beat it applies a per-block, per-timestep signed affine (alpha*s + beta) to a CH-wide binary spike vector and emits the sign spike.
- Coefficients live in an internal run-time-writable register file rather than a fixed ROM.
- Adds a frame FSM with a start/done protocol, valid/ready handshaking on input and output, and a registered output.
- Sits between a spiking attention/MLP block and the next spiking layer.

---
 rtl/spike_affine_norm_if.sv | 48 ++++
 rtl/spike_affine_norm.sv | 143 ++++++++++++++
 tb/tb_spike_affine_norm.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_affine_norm_if.sv
`default_nettype none
// ============================================================================
// Module      : spike_affine_norm_if
// Description : Control, configuration and streaming bundle for the spiking
//               per-timestep affine normalisation stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface spike_affine_norm_if #(
  parameter int CH   = 16,
  parameter int T    = 30,
  parameter int CW   = 8,
  parameter int NBLK = 8,
  parameter int TW   = $clog2(T),
  parameter int BW   = $clog2(NBLK)
);
  logic                 start;
  logic [BW-1:0]        block_sel;
  logic                 cfg_we;
  logic [BW-1:0]        cfg_blk;
  logic [TW-1:0]        cfg_t;
  logic signed [CW-1:0] cfg_alpha;
  logic signed [CW-1:0] cfg_beta;
  logic                 in_valid;
  logic                 in_ready;
  logic [CH-1:0]        in_spike;
  logic                 out_valid;
  logic                 out_ready;
  logic [CH-1:0]        out_spike;
  logic [TW-1:0]        out_t;
  logic                 busy;
  logic                 done;
  logic                 err_idle_beat;

  // Driver side: controller / upstream / downstream environment
  modport master (
    output start, block_sel, cfg_we, cfg_blk, cfg_t, cfg_alpha, cfg_beta,
    output in_valid, in_spike, out_ready,
    input  in_ready, out_valid, out_spike, out_t, busy, done, err_idle_beat
  );

  // Normalisation stage side
  modport slave (
    input  start, block_sel, cfg_we, cfg_blk, cfg_t, cfg_alpha, cfg_beta,
    input  in_valid, in_spike, out_ready,
    output in_ready, out_valid, out_spike, out_t, busy, done, err_idle_beat
  );
endinterface
`default_nettype wire

// File: rtl/spike_affine_norm.sv
`default_nettype none
// ============================================================================
// Module      : spike_affine_norm
// Description : Per-timestep signed affine (alpha*s + beta) on a binary spike
//               vector with sign-spike output, run-time coefficient file,
//               frame FSM and valid/ready streaming with registered output.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_affine_norm #(
  parameter int CH   = 16,
  parameter int T    = 30,
  parameter int CW   = 8,
  parameter int NBLK = 8,
  parameter int TW   = $clog2(T),
  parameter int BW   = $clog2(NBLK)
) (
  input  logic               clk,
  input  logic               rst_n,
  spike_affine_norm_if.slave bus
);

  localparam int            IW          = $clog2(NBLK * T);
  localparam logic [TW-1:0] c_TLAST     = TW'(T - 1);
  localparam logic [TW:0]   c_T_LIM     = (TW + 1)'(T);
  localparam logic [BW:0]   c_NBLK_LIM  = (BW + 1)'(NBLK);

  localparam logic [1:0]    S_IDLE      = 2'd0;
  localparam logic [1:0]    S_RUN       = 2'd1;
  localparam logic [1:0]    S_DONE      = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_next;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_in_ready;
  logic                 w_accept;

  logic [TW-1:0]        r_t;
  logic [BW-1:0]        r_blk;
  logic                 r_err;
  logic                 r_ov;
  logic [CH-1:0]        r_os;
  logic [TW-1:0]        r_ot;

  logic signed [CW-1:0] r_alpha [NBLK*T];
  logic signed [CW-1:0] r_beta  [NBLK*T];
  logic [IW-1:0]        w_rd_idx;
  logic [IW-1:0]        w_wr_idx;
  logic                 w_cfg_ok;
  logic signed [CW:0]   w_alpha_x;
  logic signed [CW:0]   w_beta_x;
  logic [CH-1:0]        w_spike;

  assign w_accept = bus.in_valid & w_in_ready;

  // Coefficient addressing: flat [blk][t] layout, out-of-range writes dropped
  assign w_rd_idx = IW'(r_blk) * IW'(T) + IW'(r_t);
  assign w_wr_idx = IW'(bus.cfg_blk) * IW'(T) + IW'(bus.cfg_t);
  assign w_cfg_ok = ({1'b0, bus.cfg_t} < c_T_LIM) && ({1'b0, bus.cfg_blk} < c_NBLK_LIM);

  // Sign-extend by one bit so alpha+beta can never wrap
  assign w_alpha_x = {r_alpha[w_rd_idx][CW-1], r_alpha[w_rd_idx]};
  assign w_beta_x  = {r_beta[w_rd_idx][CW-1],  r_beta[w_rd_idx]};

  // Per-channel affine and sign: spike selects alpha+beta, otherwise beta alone
  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic signed [CW:0] w_v;
    assign w_v          = bus.in_spike[gi] ? (w_alpha_x + w_beta_x) : w_beta_x;
    assign w_spike[gi]  = ~w_v[CW] & (|w_v);
  end

  // Coefficient file: plain storage, no reset; reads see the pre-write value
  always_ff @(posedge clk) begin
    if (bus.cfg_we && w_cfg_ok) begin
      r_alpha[w_wr_idx] <= bus.cfg_alpha;
      r_beta[w_wr_idx]  <= bus.cfg_beta;
    end
  end

  // Frame FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Frame FSM next-state: start opens a frame, the T-th accepted beat closes it
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_accept && (r_t == c_TLAST)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Frame FSM outputs: input accepted only when the output slot is free or draining
  always_comb begin
    w_busy     = (r_state == S_RUN);
    w_done     = (r_state == S_DONE);
    w_in_ready = (r_state == S_RUN) && (!r_ov || bus.out_ready);
  end

  // Frame context, idle-beat error flag and registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t   <= '0;
      r_blk <= '0;
      r_err <= 1'b0;
      r_ov  <= 1'b0;
      r_os  <= '0;
      r_ot  <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        if (bus.start) begin
          r_blk <= bus.block_sel;
          r_t   <= '0;
          r_err <= 1'b0;
        end else if (bus.in_valid) begin
          r_err <= 1'b1;
        end
      end
      if (w_accept) begin
        r_os <= w_spike;
        r_ot <= r_t;
        r_ov <= 1'b1;
        r_t  <= (r_t == c_TLAST) ? '0 : r_t + TW'(1);
      end else if (bus.out_ready) begin
        r_ov <= 1'b0;
      end
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.busy          = w_busy;
  assign bus.done          = w_done;
  assign bus.out_valid     = r_ov;
  assign bus.out_spike     = r_os;
  assign bus.out_t         = r_ot;
  assign bus.err_idle_beat = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spike_affine_norm.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_affine_norm
// Description : Self-checking bench for spike_affine_norm with a cycle-level
//               behavioural model of frames, handshakes and coefficients.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_affine_norm;

  localparam int CH   = 16;
  localparam int T    = 30;
  localparam int CW   = 8;
  localparam int NBLK = 8;
  localparam int TW   = $clog2(T);
  localparam int BW   = $clog2(NBLK);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  spike_affine_norm_if #(.CH(CH), .T(T), .CW(CW), .NBLK(NBLK)) bus ();

  spike_affine_norm #(.CH(CH), .T(T), .CW(CW), .NBLK(NBLK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_e;
  mstate_e       m_state = M_IDLE;
  int            m_t = 0, m_blk = 0, m_ot = 0;
  bit            m_err = 0, m_ov = 0;
  logic [CH-1:0] m_os = '0;
  int            ma [NBLK][T];
  int            mb [NBLK][T];
  int            done_cnt = 0;
  bit            last_acc = 0;

  // Sign of the affine value per channel, computed in full-precision integers
  function automatic logic [CH-1:0] ref_out(input logic [CH-1:0] s, input int a, input int b);
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) begin
      int v;
      v    = s[i] ? (a + b) : b;
      r[i] = (v > 0);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check outputs mid-cycle, then advance the model across the next rising edge
  task automatic step();
    bit rdy_exp, acc, wr;
    @(negedge clk);
    rdy_exp = (m_state == M_RUN) && (!m_ov || bus.out_ready);
    chk("in_ready", 32'(bus.in_ready), 32'(rdy_exp));
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("out_spike", 32'(bus.out_spike), 32'(m_os));
      chk("out_t", 32'(bus.out_t), 32'(m_ot));
    end
    chk("busy", 32'(bus.busy), 32'(m_state == M_RUN));
    chk("done", 32'(bus.done), 32'(m_state == M_DONE));
    chk("err_idle_beat", 32'(bus.err_idle_beat), 32'(m_err));
    if (m_state == M_DONE) done_cnt++;

    acc      = rdy_exp && bus.in_valid;
    last_acc = acc;
    wr       = bus.cfg_we && (int'(bus.cfg_t) < T) && (int'(bus.cfg_blk) < NBLK);
    case (m_state)
      M_IDLE: begin
        if (bus.start) begin
          m_state = M_RUN; m_blk = int'(bus.block_sel); m_t = 0; m_err = 0;
        end else if (bus.in_valid) begin
          m_err = 1;
        end
      end
      M_RUN: begin
        if (acc) begin
          m_os = ref_out(bus.in_spike, ma[m_blk][m_t], mb[m_blk][m_t]);
          m_ot = m_t;
          m_ov = 1;
          if (m_t == T - 1) begin m_t = 0; m_state = M_DONE; end
          else m_t++;
        end
      end
      default: m_state = M_IDLE;
    endcase
    if (!acc && bus.out_ready) m_ov = 0;
    if (wr) begin
      ma[bus.cfg_blk][bus.cfg_t] = int'($signed(bus.cfg_alpha));
      mb[bus.cfg_blk][bus.cfg_t] = int'($signed(bus.cfg_beta));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int b, input int t, input int a, input int bb);
    bus.cfg_we    = 1'b1;
    bus.cfg_blk   = BW'(b);
    bus.cfg_t     = TW'(t);
    bus.cfg_alpha = a[CW-1:0];
    bus.cfg_beta  = bb[CW-1:0];
    step();
    bus.cfg_we    = 1'b0;
  endtask

  // Asynchronous reset pulse asserted between clock edges
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_spike", 32'(bus.out_spike), 32'd0);
    chk("rst_out_t", 32'(bus.out_t), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err_idle_beat), 32'd0);
    m_state = M_IDLE; m_t = 0; m_blk = 0; m_err = 0; m_ov = 0; m_os = '0; m_ot = 0;
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    bus.cfg_we   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int blk, input bit use_fixed, input logic [CH-1:0] fixed_s,
                           input int stall_t, input int inj_t, input int inj_a, input int inj_b,
                           input int abort_t, input bit rand_ready);
    int acc_n, cyc, stall_n;
    bit injd;
    done_cnt      = 0;
    bus.block_sel = BW'(blk);
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.start     = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_spike  = use_fixed ? fixed_s : CH'($urandom);
    acc_n = 0; cyc = 0; stall_n = 0; injd = 0;
    while (acc_n < T && cyc < 300) begin
      if (abort_t >= 0 && m_t == abort_t) begin
        apply_reset();
        return;
      end
      if (stall_t >= 0 && m_ov && m_ot == stall_t && stall_n < 4) begin
        bus.out_ready = 1'b0;
        stall_n++;
      end else begin
        bus.out_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
      end
      if (inj_t >= 0 && !injd && m_t == inj_t && (!m_ov || bus.out_ready)) begin
        bus.cfg_we    = 1'b1;
        bus.cfg_blk   = BW'(blk);
        bus.cfg_t     = TW'(inj_t);
        bus.cfg_alpha = inj_a[CW-1:0];
        bus.cfg_beta  = inj_b[CW-1:0];
        injd = 1;
      end
      step();
      bus.cfg_we = 1'b0;
      cyc++;
      if (last_acc) begin
        acc_n++;
        bus.in_spike = use_fixed ? fixed_s : CH'($urandom);
      end
    end
    chk("beats_accepted", 32'(acc_n), 32'(T));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    chk("done_pulses", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    bus.start = 0; bus.block_sel = '0; bus.cfg_we = 0; bus.cfg_blk = '0; bus.cfg_t = '0;
    bus.cfg_alpha = '0; bus.cfg_beta = '0; bus.in_valid = 0; bus.in_spike = '0; bus.out_ready = 0;

    // Power-on reset
    #12;
    chk("por_out_valid", 32'(bus.out_valid), 32'd0);
    chk("por_busy", 32'(bus.busy), 32'd0);
    chk("por_done", 32'(bus.done), 32'd0);
    chk("por_err", 32'(bus.err_idle_beat), 32'd0);
    chk("por_out_t", 32'(bus.out_t), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step();

    // Fill every coefficient with random signed values
    for (int b = 0; b < NBLK; b++)
      for (int t = 0; t < T; t++)
        cfg_write(b, t, int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);

    // Block 2: alpha=+5, beta=-3 -> output equals input spikes
    for (int t = 0; t < T; t++) cfg_write(2, t, 5, -3);
    run_frame(2, 1, 16'hA5A5, -1, -1, 0, 0, -1, 0);

    // Block 0 timestep 7 boundary coefficients
    cfg_write(0, 7, 3, -3);
    run_frame(0, 0, '0, -1, -1, 0, 0, -1, 0);
    cfg_write(0, 7, -128, -128);
    run_frame(0, 0, '0, -1, -1, 0, 0, -1, 0);
    cfg_write(0, 7, 127, 127);
    run_frame(0, 1, 16'h3C96, -1, -1, 0, 0, -1, 0);

    // Downstream stall after beat 3
    run_frame(3, 0, '0, 3, -1, 0, 0, -1, 0);

    // Beats offered while idle
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) step();
    bus.in_valid = 1'b0;
    step();

    // Out-of-range timestep write must not disturb any stored entry
    cfg_write(1, 1, 6, -2);
    cfg_write(0, 31, -100, -100);
    cfg_write(7, 30, -100, -100);
    run_frame(1, 0, '0, -1, -1, 0, 0, -1, 0);

    // Write to the entry in use on the accepting edge: old value applies first
    cfg_write(1, 5, 4, 2);
    run_frame(1, 0, '0, -1, 5, -4, -2, -1, 0);
    run_frame(1, 0, '0, -1, -1, 0, 0, -1, 0);

    // Randomized frames with random downstream backpressure
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 4; k++)
        cfg_write(int'($urandom_range(NBLK - 1)), int'($urandom_range(T - 1)),
                  int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
      run_frame(int'($urandom_range(NBLK - 1)), 0, '0, -1, -1, 0, 0, -1, 1);
    end

    // Reset in the middle of a frame
    done_cnt = 0;
    run_frame(4, 0, '0, -1, -1, 0, 0, 12, 0);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) step();
    bus.in_valid = 1'b0;
    step();
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    run_frame(4, 0, '0, -1, -1, 0, 0, -1, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
